// File: rtl/led_blink_timer_pkg.sv
// Shared register map and CTRL bit layout for the LED blink timer.
package led_blink_timer_pkg;

  // Register offsets within the 4-word window (per_addr[1:0]).
  typedef enum logic [1:0] {
    RegCtrl     = 2'd0,
    RegPeriod   = 2'd1,
    RegCount    = 2'd2,
    RegPrescale = 2'd3
  } reg_off_e;

  // CTRL bit positions.
  localparam int unsigned CtrlEn   = 0;
  localparam int unsigned CtrlMan  = 1;
  localparam int unsigned CtrlMode = 2;
  localparam int unsigned CtrlIe   = 3;
  localparam int unsigned CtrlIfg  = 4;

  localparam int unsigned CtrlWidth = 5;

endpackage

// File: rtl/led_blink_timer_tick_gen.sv
// Prescaler: counts 0..div and pulses tick on the cycle pcnt equals div.
module blink_tick_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] pcnt_q, pcnt_d;

  // Tick and next count; a clear restarts the interval and suppresses the tick.
  always_comb begin
    tick   = en && !clr && (pcnt_q == div);
    pcnt_d = pcnt_q + 8'd1;
    if (!en || clr || (pcnt_q == div)) begin
      pcnt_d = 8'd0;
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= 8'd0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/led_blink_timer.sv
// LED blink timer peripheral: bus registers, interval counter, LED and IRQ.
module led_blink_timer
  import led_blink_timer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic [7:0]  per_addr,
  input  logic [15:0] per_din,
  output logic [15:0] per_dout,
  output logic        led,
  output logic        irq
);

  logic     sel;
  reg_off_e offset;
  logic     ctrl_wr, period_wr, prescale_wr;
  logic     tick, wrap;

  logic        en_q, man_q, mode_q, ie_q, ifg_q, led_q;
  logic        en_d, man_d, mode_d, ie_d, ifg_d, led_d;
  logic [15:0] period_q, period_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  prescale_q, prescale_d;

  assign sel         = per_en && (per_addr[7:2] == BASE_ADDR[7:2]);
  assign offset      = reg_off_e'(per_addr[1:0]);
  assign ctrl_wr     = sel && (offset == RegCtrl) && per_we[0];
  assign period_wr   = sel && (offset == RegPeriod) && (per_we != 2'b00);
  assign prescale_wr = sel && (offset == RegPrescale) && per_we[0];

  // A PERIOD write clears the prescaler so the new interval starts cleanly.
  blink_tick_gen u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en_q),
    .clr  (period_wr),
    .div  (prescale_q),
    .tick (tick)
  );

  assign wrap = tick && (count_q == 16'd0);

  // Next-state for control, period, prescale, count and LED state.
  always_comb begin
    en_d       = en_q;
    man_d      = man_q;
    mode_d     = mode_q;
    ie_d       = ie_q;
    ifg_d      = ifg_q;
    led_d      = led_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    count_d    = count_q;

    if (ctrl_wr) begin
      en_d   = per_din[CtrlEn];
      man_d  = per_din[CtrlMan];
      mode_d = per_din[CtrlMode];
      ie_d   = per_din[CtrlIe];
      if (per_din[CtrlIfg]) begin
        ifg_d = 1'b0;
      end
    end

    // Hardware set is applied after the software clear so it wins.
    if (wrap) begin
      led_d = ~led_q;
      ifg_d = 1'b1;
    end

    if (period_wr && per_we[0]) begin
      period_d[7:0] = per_din[7:0];
    end
    if (period_wr && per_we[1]) begin
      period_d[15:8] = per_din[15:8];
    end

    if (prescale_wr) begin
      prescale_d = per_din[7:0];
    end

    if (period_wr) begin
      count_d = period_d;
    end else if (!en_q) begin
      count_d = period_q;
    end else if (tick) begin
      count_d = (count_q == 16'd0) ? period_q : count_q - 16'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= 1'b0;
      man_q      <= 1'b0;
      mode_q     <= 1'b0;
      ie_q       <= 1'b0;
      ifg_q      <= 1'b0;
      led_q      <= 1'b0;
      period_q   <= 16'd0;
      prescale_q <= 8'd0;
      count_q    <= 16'd0;
    end else begin
      en_q       <= en_d;
      man_q      <= man_d;
      mode_q     <= mode_d;
      ie_q       <= ie_d;
      ifg_q      <= ifg_d;
      led_q      <= led_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
    end
  end

  // Read mux; zero unless this block is addressed for a read, so buses can be ORed.
  always_comb begin
    per_dout = 16'd0;
    if (sel && (per_we == 2'b00)) begin
      unique case (offset)
        RegCtrl:     per_dout = {11'd0, ifg_q, ie_q, mode_q, man_q, en_q};
        RegPeriod:   per_dout = period_q;
        RegCount:    per_dout = count_q;
        RegPrescale: per_dout = {8'd0, prescale_q};
        default:     per_dout = 16'd0;
      endcase
    end
  end

  assign led = mode_q ? led_q : man_q;
  assign irq = ie_q & ifg_q;

endmodule

// File: tb/tb_led_blink_timer.sv
// Self-checking bench for led_blink_timer with an interval-phase reference model.
module tb_led_blink_timer;

  localparam logic [7:0] BASE = 8'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = 2'b00;
  logic [7:0]  per_addr = 8'h00;
  logic [15:0] per_din = 16'h0000;
  logic [15:0] per_dout;
  logic        led, irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  led_blink_timer #(
    .BASE_ADDR (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_dout (per_dout),
    .led      (led),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Model: m_ph is the number of cycles elapsed in the current LED interval,
  // whose length is (PERIOD+1)*(PRESCALE+1); COUNT follows from the phase.
  bit m_en = 0, m_man = 0, m_mode = 0, m_ie = 0, m_ifg = 0, m_led = 0;
  int m_period = 0, m_prescale = 0, m_ph = 0;
  bit ms_sel, ms_pw, ms_tgl;
  int ms_len;

  function automatic int m_count();
    return m_period - m_ph / (m_prescale + 1);
  endfunction

  function automatic logic [15:0] exp_dout();
    logic [15:0] v;
    v = 16'h0000;
    if (per_en && per_addr[7:2] == BASE[7:2] && per_we == 2'b00) begin
      case (per_addr[1:0])
        2'd0: v = {11'd0, m_ifg, m_ie, m_mode, m_man, m_en};
        2'd1: v = 16'(m_period);
        2'd2: v = 16'(m_count());
        default: v = 16'(m_prescale);
      endcase
    end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en = 0; m_man = 0; m_mode = 0; m_ie = 0; m_ifg = 0; m_led = 0;
      m_period = 0; m_prescale = 0; m_ph = 0;
    end else begin
      cyc++;
      ms_sel = per_en && (per_addr[7:2] == BASE[7:2]);
      ms_pw  = ms_sel && per_addr[1:0] == 2'd1 && per_we != 2'b00;
      ms_tgl = 0;
      ms_len = (m_period + 1) * (m_prescale + 1);
      if (!m_en || ms_pw) m_ph = 0;
      else if (m_ph == ms_len - 1) begin m_ph = 0; ms_tgl = 1; end
      else m_ph++;
      if (ms_sel && per_addr[1:0] == 2'd0 && per_we[0]) begin
        m_en = per_din[0]; m_man = per_din[1]; m_mode = per_din[2]; m_ie = per_din[3];
        if (per_din[4]) m_ifg = 0;
      end
      if (ms_tgl) begin m_led = !m_led; m_ifg = 1; end
      if (ms_pw && per_we[0]) m_period = (m_period & 32'hFF00) | int'(per_din[7:0]);
      if (ms_pw && per_we[1]) m_period = (m_period & 32'h00FF) | (int'(per_din[15:8]) << 8);
      if (ms_sel && per_addr[1:0] == 2'd3 && per_we[0]) m_prescale = int'(per_din[7:0]);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h time=%0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of outputs against the model.
  always @(negedge clk) begin
    check("led_model", 32'(led), 32'(m_mode ? m_led : m_man));
    check("irq_model", 32'(irq), 32'(m_ie & m_ifg));
    check("dout_model", 32'(per_dout), 32'(exp_dout()));
  end

  task automatic bus_write(input logic [1:0] off, input logic [1:0] we, input logic [15:0] d);
    per_en = 1'b1; per_we = we; per_addr = BASE + {6'd0, off}; per_din = d;
    @(posedge clk); #1;
    per_en = 1'b0; per_we = 2'b00; per_din = 16'h0000;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [15:0] d);
    per_en = 1'b1; per_we = 2'b00; per_addr = addr;
    @(negedge clk);
    d = per_dout;
    @(posedge clk); #1;
    per_en = 1'b0;
  endtask

  // Returns the clock-edge number at which led changed.
  task automatic wait_toggle(output int at);
    logic old;
    old = led;
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (led !== old) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL toggle_timeout got=none exp=toggle_within_200 time=%0t", $time);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] d;
    int t1, t2, t3, wcyc;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    for (int o = 0; o < 4; o++) begin
      bus_read(BASE + 8'(o), d);
      check("reset_read", 32'(d), 32'h0);
    end
    check("reset_led", 32'(led), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);

    // PERIOD=3, PRESCALE=0, enable blink with IE.
    bus_write(2'd1, 2'b11, 16'd3);
    bus_write(2'd3, 2'b11, 16'd0);
    bus_write(2'd0, 2'b01, 16'h000D);
    wcyc = cyc;
    wait_toggle(t1);
    check("first_toggle_delay", 32'(t1 - wcyc), 32'd4);
    check("first_toggle_led", 32'(led), 32'h1);
    check("first_toggle_irq", 32'(irq), 32'h1);
    wait_toggle(t2);
    check("toggle_period_4", 32'(t2 - t1), 32'd4);

    // IFG clear coinciding with a toggle: set wins.
    for (int i = 0; i < 20 && m_ph != 3; i++) begin
      @(posedge clk); #1;
    end
    bus_write(2'd0, 2'b01, 16'h001D);
    bus_read(BASE, d);
    check("ctrl_ifg_set_wins", 32'(d), 32'h001D);
    if (m_ph == 3) begin
      @(posedge clk); #1;
    end
    bus_write(2'd0, 2'b01, 16'h001D);
    check("irq_cleared", 32'(irq), 32'h0);

    // PERIOD=1, PRESCALE=2 -> 6-cycle toggle interval.
    bus_write(2'd0, 2'b01, 16'h000C);
    bus_write(2'd3, 2'b01, 16'd2);
    bus_write(2'd1, 2'b11, 16'd1);
    bus_write(2'd0, 2'b01, 16'h000D);
    wcyc = cyc;
    wait_toggle(t1);
    check("toggle_delay_6", 32'(t1 - wcyc), 32'd6);
    wait_toggle(t2);
    check("toggle_period_6", 32'(t2 - t1), 32'd6);
    repeat (2) begin
      @(posedge clk); #1;
    end
    bus_write(2'd1, 2'b11, 16'd1);
    wcyc = cyc;
    wait_toggle(t3);
    check("period_write_restart", 32'(t3 - wcyc), 32'd6);

    // Manual mode: LED follows MAN, counting continues.
    bus_write(2'd0, 2'b01, 16'h000B);
    check("manual_led", 32'(led), 32'h1);
    bus_read(BASE + 8'd2, d);
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus_read(BASE + 8'd2, d);
    bus_read(BASE + 8'd4, d);
    check("unaddressed_read", 32'(d), 32'h0);
    bus_write(2'd0, 2'b01, 16'h000D);

    // High-byte-only PERIOD write, then reset mid-count.
    bus_write(2'd1, 2'b11, 16'h0012);
    bus_write(2'd1, 2'b10, 16'hAB00);
    bus_read(BASE + 8'd1, d);
    check("period_byte_write", 32'(d), 32'hAB12);
    bus_write(2'd0, 2'b01, 16'h000B);
    repeat (10) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #3 rst = 1'b1;
    @(negedge clk);
    check("rst_led", 32'(led), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus_read(BASE + 8'd2, d);
    check("rst_count", 32'(d), 32'h0);
    bus_read(BASE, d);
    check("rst_ctrl", 32'(d), 32'h0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("rst_no_residual_led", 32'(led), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_blink_timer.md
LED_BLINK_TIMER -- requirements
Module: led_blink_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h10: word address of register 0 on the peripheral bus.
REQ-002 SHALL have port clk, input, 1: clock, shared with the CPU dco_clk.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port per_en, input, 1: peripheral access strobe, active-high.
REQ-005 SHALL have port per_we, input, 2: byte write enables; bit0 writes the low byte, bit1 writes the high byte.
REQ-006 SHALL have port per_addr, input, 8: word address.
REQ-007 SHALL have port per_din, input, 16: write data.
REQ-008 SHALL have port per_dout, output, 16: read data; all-zero when this block is not addressed, so outputs can be ORed.
REQ-009 SHALL have port led, output, 1: LED drive.
REQ-010 SHALL have port irq, output, 1: interrupt request, active-high level.

Function
REQ-011 Register decode SHALL be sel = per_en and (per_addr[7:2] == BASE_ADDR[7:2]); offset = per_addr[1:0].
REQ-012 Offset 0 SHALL be CTRL, 5 bits:
- EN at bit0
- MAN at bit1 (manual LED value)
- MODE at bit2 (0 = manual, 1 = blink)
- IE at bit3
- IFG at bit4
- Reads return bits 15:5 as 0.
REQ-013 Offset 1 SHALL be PERIOD, 16-bit read/write.
REQ-014 Offset 2 SHALL be COUNT, 16-bit read-only; writes are ignored.
REQ-015 Offset 3 SHALL be PRESCALE, 8 bits in [7:0]; reads return [15:8] as 0.
REQ-016 Writes SHALL take effect at the clk edge where sel and the per_we bit are high; each byte lane is independent.
REQ-017 per_dout SHALL be combinational from register state when sel is high and per_we is 0; otherwise it SHALL be 0.
REQ-018 Writing 1 to IFG SHALL clear it; writing 0 SHALL have no effect; software cannot set IFG.
REQ-019 The prescaler SHALL behave as follows while EN=1:
- pcnt counts 0..PRESCALE, then wraps to 0.
- tick is asserted for the one cycle where pcnt==PRESCALE.
REQ-020 On tick, if COUNT==0: led_q SHALL toggle, COUNT SHALL reload from PERIOD, and IFG SHALL set. Otherwise COUNT SHALL decrement by 1.
REQ-021 The LED toggle period SHALL be (PERIOD+1)*(PRESCALE+1) clk cycles.
- PERIOD=0 with PRESCALE=0 toggles every cycle.
- The counter width is fixed; there is no overflow path.
REQ-022 While EN=0:
- pcnt SHALL be held at 0.
- COUNT SHALL be held equal to PERIOD.
- led_q SHALL hold its value.
REQ-023 A write to any byte of PERIOD SHALL also load COUNT with the new PERIOD value and clear pcnt in the same edge, restarting the interval.
REQ-024 If IFG set (REQ-020) and an IFG clear write occur in the same cycle, set SHALL win.
REQ-025 led SHALL be MODE ? led_q : MAN, combinational.
REQ-026 irq SHALL be IE and IFG, combinational.
REQ-027 Changing MODE SHALL NOT alter led_q or COUNT.

Reset
REQ-028 While rst=1, all registers SHALL be cleared: CTRL=0, PERIOD=0, PRESCALE=0, COUNT=0, pcnt=0, led_q=0.
REQ-029 Consequently led=0, irq=0 and per_dout=0 during and immediately after reset.
REQ-030 Reset asserted mid-interval SHALL abort counting with no residual tick.

Structure
REQ-031 A shared package SHALL hold the register offsets (CTRL=0, PERIOD=1, COUNT=2, PRESCALE=3) and the CTRL bit positions.
REQ-032 The prescaler SHALL be a sub-module blink_tick_gen with ports clk, rst, en, clr, div[7:0] and tick.
REQ-033 All other logic SHALL reside in led_blink_timer.

Verification
REQ-034 Reset, then read all 4 offsets at BASE_ADDR -> all read 0x0000; led=0; irq=0.
REQ-035 Write PERIOD=3, PRESCALE=0, CTRL=0x0D (EN, MODE, IE) -> led toggles every 4 cycles; IFG and irq rise at the first toggle.
REQ-036 Write CTRL=0x1D while a toggle occurs in the same cycle -> IFG remains 1; a subsequent write of 0x1D with no toggle -> irq=0.
REQ-037 Write PERIOD=1, PRESCALE=2 -> toggle every 6 cycles; a mid-interval PERIOD write restarts timing from that edge.
REQ-038 Set MODE=0, MAN=1 -> led=1 immediately; read COUNT -> counting continues; read at per_addr=BASE_ADDR+4 -> per_dout=0.
REQ-039 A byte write with per_we=2'b10, data 0xAB00 to PERIOD=0x0012 -> PERIOD=0xAB12; assert rst mid-count -> led=0, COUNT=0.
